// File: rtl/lift_pkg.sv
// Shared constants and types for the two-floor lift sequencer.
// Optional feature macro: LIFT_AUTO_RETURN_EN (adds the park timer default).
package lift_pkg;

  // Action codes, matching the two-digit display coder encoding
  localparam logic [2:0] ACT_DN      = 3'b000;
  localparam logic [2:0] ACT_A1      = 3'b001;
  localparam logic [2:0] ACT_UP      = 3'b010;
  localparam logic [2:0] ACT_A2      = 3'b011;
  localparam logic [2:0] ACT_R1      = 3'b100;
  localparam logic [2:0] ACT_R2      = 3'b101;
  localparam logic [2:0] ACT_NOTHING = 3'b110;

  // Default phase lengths, in ticks
  localparam int unsigned DEF_REQ_T    = 2;
  localparam int unsigned DEF_TRAVEL_T = 5;
  localparam int unsigned DEF_DWELL_T  = 4;
  localparam int unsigned DEF_TW       = 4;
`ifdef LIFT_AUTO_RETURN_EN
  localparam int unsigned DEF_PARK_T   = 8;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StReq1,
    StReq2,
    StUp,
    StDn,
    StAt1,
    StAt2
  } state_e;

  // Action code shown while in a given state
  function automatic logic [2:0] state_action(state_e s);
    logic [2:0] a;
    a = ACT_NOTHING;
    unique case (s)
      StIdle:  a = ACT_NOTHING;
      StReq1:  a = ACT_R1;
      StReq2:  a = ACT_R2;
      StUp:    a = ACT_UP;
      StDn:    a = ACT_DN;
      StAt1:   a = ACT_A1;
      StAt2:   a = ACT_A2;
      default: a = ACT_NOTHING;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/lift_action_ctrl_if.sv
// Call/timebase inputs and action/status outputs of the lift sequencer.
// master = call button / timebase side, slave = sequencer.
interface lift_action_ctrl_if;
  logic       tick;
  logic       call1;
  logic       call2;
  logic [2:0] action;
  logic       floor;
  logic       busy;

  modport master (output tick, call1, call2, input action, floor, busy);
  modport slave (input tick, call1, call2, output action, floor, busy);
endinterface

// File: rtl/lift_phase_timer.sv
// Loadable TW-bit down-counter; done flags the tick on which the count sits at zero.
module lift_phase_timer #(
  parameter int unsigned TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          tick,
  output logic          done
);

  logic [TW-1:0] cnt_q, cnt_d;

  // Load has priority; otherwise count down on ticks and hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = tick && (cnt_q == '0);

endmodule

// File: rtl/lift_action_ctrl.sv
// Two-floor lift sequencer: latches calls, times request/travel/dwell phases
// and drives the registered action code for the display coder.
// Optional feature macro: LIFT_AUTO_RETURN_EN (park at floor 1 returns to floor 1... i.e. floor 0).
module lift_action_ctrl
  import lift_pkg::*;
#(
  parameter int unsigned REQ_T    = DEF_REQ_T,
  parameter int unsigned TRAVEL_T = DEF_TRAVEL_T,
  parameter int unsigned DWELL_T  = DEF_DWELL_T,
  parameter int unsigned TW       = DEF_TW
`ifdef LIFT_AUTO_RETURN_EN
  ,
  parameter int unsigned PARK_T   = DEF_PARK_T
`endif
) (
  input logic              clk,
  input logic              rst,
  lift_action_ctrl_if.slave bus
);

  // Timers load T-1 so that a phase lasts exactly T ticks
  localparam logic [TW-1:0] ReqLd    = TW'(REQ_T - 1);
  localparam logic [TW-1:0] TravelLd = TW'(TRAVEL_T - 1);
  localparam logic [TW-1:0] DwellLd  = TW'(DWELL_T - 1);

  state_e     state_q, state_d;
  logic       floor_q, floor_d;
  logic       pend1_q, pend1_d;
  logic       pend2_q, pend2_d;
  logic [2:0] action_q;
  logic       busy_q;
  logic       eff1, eff2;
  logic       clr1, clr2;
  logic       tmr_load;
  logic [TW-1:0] tmr_val;
  logic       tmr_done;
  logic       park_done;

  assign eff1 = pend1_q | bus.call1;
  assign eff2 = pend2_q | bus.call2;

  lift_phase_timer #(
    .TW(TW)
  ) u_phase_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .tick    (bus.tick),
    .done    (tmr_done)
  );

`ifdef LIFT_AUTO_RETURN_EN
  localparam logic [TW-1:0] ParkLd = TW'(PARK_T - 1);

  logic park_arm;
  logic park_tmr_done;

  // Park timer runs only while idle at floor 2 with nothing wanted; reloads otherwise
  assign park_arm = (state_q == StIdle) && floor_q && !eff1 && !eff2;

  lift_phase_timer #(
    .TW(TW)
  ) u_park_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (!park_arm),
    .load_val(ParkLd),
    .tick    (bus.tick),
    .done    (park_tmr_done)
  );

  assign park_done = park_arm && park_tmr_done;
`else
  assign park_done = 1'b0;
`endif

  // Next-state, floor update, timer loads and pending-clear strobes
  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    clr1     = 1'b0;
    clr2     = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Current floor first, so a same-floor call skips the request phase
        if (floor_q ? eff2 : eff1) begin
          state_d  = floor_q ? StAt2 : StAt1;
          tmr_load = 1'b1;
          tmr_val  = DwellLd;
        end else if (floor_q ? eff1 : eff2) begin
          state_d  = floor_q ? StReq1 : StReq2;
          tmr_load = 1'b1;
          tmr_val  = ReqLd;
        end else if (park_done) begin
          state_d  = StDn;
          tmr_load = 1'b1;
          tmr_val  = TravelLd;
        end
      end
      StReq1: begin
        if (tmr_done) begin
          state_d  = StDn;
          tmr_load = 1'b1;
          tmr_val  = TravelLd;
        end
      end
      StReq2: begin
        if (tmr_done) begin
          state_d  = StUp;
          tmr_load = 1'b1;
          tmr_val  = TravelLd;
        end
      end
      StUp: begin
        if (tmr_done) begin
          state_d  = StAt2;
          floor_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = DwellLd;
        end
      end
      StDn: begin
        if (tmr_done) begin
          state_d  = StAt1;
          floor_d  = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = DwellLd;
        end
      end
      StAt1: begin
        if (tmr_done) begin
          state_d = StIdle;
          clr1    = 1'b1;
        end
      end
      StAt2: begin
        if (tmr_done) begin
          state_d = StIdle;
          clr2    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Calls are always latched; clearing on the dwell exit edge wins over a held call
  always_comb begin
    pend1_d = (pend1_q | bus.call1) & ~clr1;
    pend2_d = (pend2_q | bus.call2) & ~clr2;
  end

  // State, position, pending flags and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      floor_q  <= 1'b0;
      pend1_q  <= 1'b0;
      pend2_q  <= 1'b0;
      action_q <= ACT_NOTHING;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      pend1_q  <= pend1_d;
      pend2_q  <= pend2_d;
      action_q <= state_action(state_d);
      busy_q   <= (state_d != StIdle);
    end
  end

  assign bus.action = action_q;
  assign bus.floor  = floor_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_lift_action_ctrl.sv
// Self-checking bench for lift_action_ctrl: directed scenarios plus random
// calls/ticks, compared every cycle against a phase/remaining-ticks model.
module tb_lift_action_ctrl;
  import lift_pkg::*;

  localparam int unsigned REQ_T    = 2;
  localparam int unsigned TRAVEL_T = 5;
  localparam int unsigned DWELL_T  = 4;
  localparam int unsigned TW       = 4;
`ifdef LIFT_AUTO_RETURN_EN
  localparam int unsigned PARK_T   = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  lift_action_ctrl_if bus ();

  lift_action_ctrl #(
    .REQ_T   (REQ_T),
    .TRAVEL_T(TRAVEL_T),
    .DWELL_T (DWELL_T),
    .TW      (TW)
`ifdef LIFT_AUTO_RETURN_EN
    ,
    .PARK_T  (PARK_T)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: displayed action, ticks left in the phase, position, pending calls
  logic [2:0] m_act;
  int         m_left;
  bit         m_floor;
  bit         m_p1, m_p2;
  int         m_park;

  int hist[8];

  function automatic void model_reset();
    m_act   = ACT_NOTHING;
    m_left  = 0;
    m_floor = 1'b0;
    m_p1    = 1'b0;
    m_p2    = 1'b0;
    m_park  = 0;
  endfunction

  function automatic void model_step(input bit t, input bit c1, input bit c2);
    bit e1, e2, here, there;
    e1 = m_p1 | c1;
    e2 = m_p2 | c2;
    m_p1 = e1;
    m_p2 = e2;
    if (m_act == ACT_NOTHING) begin
      here  = m_floor ? e2 : e1;
      there = m_floor ? e1 : e2;
      if (here) begin
        m_act  = m_floor ? ACT_A2 : ACT_A1;
        m_left = DWELL_T;
        m_park = 0;
      end else if (there) begin
        m_act  = m_floor ? ACT_R1 : ACT_R2;
        m_left = REQ_T;
        m_park = 0;
      end
`ifdef LIFT_AUTO_RETURN_EN
      else if (m_floor && t) begin
        m_park = m_park + 1;
        if (m_park == PARK_T) begin
          m_act  = ACT_DN;
          m_left = TRAVEL_T;
          m_park = 0;
        end
      end
`endif
    end else if (t) begin
      if (m_left > 1) begin
        m_left = m_left - 1;
      end else begin
        case (m_act)
          ACT_R2: begin m_act = ACT_UP; m_left = TRAVEL_T; end
          ACT_R1: begin m_act = ACT_DN; m_left = TRAVEL_T; end
          ACT_UP: begin m_act = ACT_A2; m_left = DWELL_T; m_floor = 1'b1; end
          ACT_DN: begin m_act = ACT_A1; m_left = DWELL_T; m_floor = 1'b0; end
          ACT_A1: begin m_act = ACT_NOTHING; m_p1 = 1'b0; end
          ACT_A2: begin m_act = ACT_NOTHING; m_p2 = 1'b0; end
          default: m_act = ACT_NOTHING;
        endcase
      end
    end
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    total++;
    assert (got == exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/action"}, {5'b0, bus.action}, {5'b0, m_act});
    check({tag, "/floor"}, {7'b0, bus.floor}, {7'b0, m_floor});
    check({tag, "/busy"}, {7'b0, bus.busy}, {7'b0, (m_act != ACT_NOTHING)});
  endtask

  // One clk: drive inputs, advance model on the edge, sample 1ns after it
  task automatic cyc(input bit t, input bit c1, input bit c2, input string tag);
    bus.tick  = t;
    bus.call1 = c1;
    bus.call2 = c2;
    @(posedge clk);
    model_step(t, c1, c2);
    #1;
    check_all(tag);
    if (!$isunknown(bus.action)) hist[bus.action]++;
  endtask

  task automatic clear_hist();
    foreach (hist[i]) hist[i] = 0;
  endtask

  // Reset asserted and released mid-cycle; outputs must react without a clk edge
  task automatic do_reset(input string tag);
    bus.tick  = 1'b1;
    bus.call1 = 1'b0;
    bus.call2 = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_all({tag, "/async"});
    @(posedge clk);
    #1;
    check_all({tag, "/held"});
    #3 rst = 1'b0;
    @(posedge clk);
    model_step(1'b1, 1'b0, 1'b0);
    #1;
    check_all({tag, "/release"});
  endtask

  bit rt, rc1, rc2;

  initial begin
    bus.tick  = 1'b0;
    bus.call1 = 1'b0;
    bus.call2 = 1'b0;
    model_reset();
    clear_hist();
    @(posedge clk);
    #1;

    // Reset from power-up, then stay idle for 20 cycles
    do_reset("reset_idle");
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, "idle_hold");

    // Full trip up with a one-cycle call2 pulse
    clear_hist();
    cyc(1'b1, 1'b0, 1'b1, "trip_up");
    for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 1'b0, "trip_up");
    check_int("trip_up/r2_len", hist[ACT_R2], REQ_T);
    check_int("trip_up/up_len", hist[ACT_UP], TRAVEL_T);
    check_int("trip_up/a2_len", hist[ACT_A2], DWELL_T);

    // Merged/queued: already at floor 2, go down, then call2 + call1 during up
    for (int i = 0; i < 20; i++) cyc(1'b1, (i == 0), 1'b0, "go_down");
    clear_hist();
    cyc(1'b1, 1'b0, 1'b1, "merge");
    for (int i = 0; i < 40; i++) cyc(1'b1, (i == 5), (i == 6), "merge");
    check_int("merge/r2_len", hist[ACT_R2], REQ_T);
    check_int("merge/r1_len", hist[ACT_R1], REQ_T);
    check_int("merge/dn_len", hist[ACT_DN], TRAVEL_T);
    check_int("merge/a1_len", hist[ACT_A1], DWELL_T);

    // Same-floor call at floor 1: straight to dwell
    clear_hist();
    cyc(1'b1, 1'b1, 1'b0, "same_floor");
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, "same_floor");
    check_int("same_floor/a1_len", hist[ACT_A1], DWELL_T);
    check_int("same_floor/no_r1", hist[ACT_R1], 0);
    check_int("same_floor/no_up", hist[ACT_UP], 0);

    // Tick every third clk; call1 lands between ticks during travel
    clear_hist();
    for (int c = 0; c < 40; c++) cyc(((c % 3) == 0) && (c != 0), (c == 10), (c == 0), "gated");
    check_int("gated/r2_clk", hist[ACT_R2], 6);
    check_int("gated/up_clk", hist[ACT_UP], 15);
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, 1'b0, "gated_drain");
    check_int("gated/call1_served", hist[ACT_DN], TRAVEL_T);

    // Reset during the fifth cycle of up travel; no pending call may survive
    cyc(1'b1, 1'b0, 1'b1, "rst_up");
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, "rst_up");
    check("rst_up/in_up", {5'b0, bus.action}, {5'b0, ACT_UP});
    do_reset("rst_up");
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, "rst_up_idle");

    // Trip to floor 2, then sit idle there
    cyc(1'b1, 1'b0, 1'b1, "park");
    for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, 1'b0, "park");
    clear_hist();
    for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, 1'b0, "park");
`ifdef LIFT_AUTO_RETURN_EN
    check_int("park/dn_len", hist[ACT_DN], TRAVEL_T);
    check_int("park/a1_len", hist[ACT_A1], DWELL_T);
    check_int("park/no_r1", hist[ACT_R1], 0);
`else
    check_int("park/stays", hist[ACT_NOTHING], 30);
`endif

    // Reset while dwelling at floor 2 drops position back to floor 1
    cyc(1'b1, 1'b1, 1'b1, "rst_at2");
    for (int i = 0; i < 40; i++) begin
      if (bus.action == ACT_A2) break;
      cyc(1'b1, 1'b0, 1'b0, "rst_at2");
    end
    do_reset("rst_at2");

    // Random calls and tick gating with occasional resets
    for (int i = 0; i < 800; i++) begin
      rt  = ($urandom_range(0, 3) != 0);
      rc1 = ($urandom_range(0, 15) == 0);
      rc2 = ($urandom_range(0, 15) == 0);
      cyc(rt, rc1, rc2, "rand");
      if ($urandom_range(0, 199) == 0) do_reset("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lift_action_ctrl.md
Name: lift_action_ctrl

Overview:
- Two-floor lift sequencer. It latches floor calls, times the request, travel and dwell phases, and drives the 3-bit action code consumed by the two-digit action display coder.
- Sits between the debounced call buttons and the display coder. The action code is the block's only view of the lift.

Parameters:
- REQ_T, 2, ticks the request indication (r1/r2) is shown before travel starts
- TRAVEL_T, 5, ticks spent moving between floors (up/dn)
- DWELL_T, 4, ticks spent at a floor after arrival (A1/A2)
- TW, 4, width of the phase timer; every *_T must be between 1 and 2^TW-1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  single-cycle timebase enable; all phase timing counts ticks
- call1  in  1  call for floor 1, sampled every clk, level or pulse
- call2  in  1  call for floor 2, sampled every clk, level or pulse
- action  out  3  registered action code: dn=000, A1=001, up=010, A2=011, r1=100, r2=101, nothing=110
- floor  out  1  registered current/last floor: 0 = floor 1, 1 = floor 2
- busy  out  1  registered; 1 in every state except IDLE

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: state IDLE, action=110, floor=0, busy=0, pending1=pending2=0, timer=0.
- Pending flags: pendingN is set on any clk edge where callN=1. It is cleared only on the exit edge of the AT state for floor N. When set and clear coincide, clear wins; a call held through that edge is dropped.
- The timer loads T-1 on entry to a timed state and decrements on each tick. The state exits on the tick where timer==0, so each timed state lasts exactly T ticks.
- States and the action code shown in each:
  - IDLE: 110.
  - REQ1: 100. REQ2: 101.
  - UP: 010. DN: 000.
  - AT1: 001. AT2: 011.
- IDLE transitions, evaluated every clk with no tick needed, using the "eff" set = pending | call:
  - If the current floor is in eff, go to AT(floor); same-floor calls skip REQ.
  - Else if the other floor is in eff, go to REQ(other).
  - A call raised in cycle n is therefore visible on action in cycle n+1.
- REQ2 -> UP and REQ1 -> DN after REQ_T ticks.
- UP -> AT2, setting floor=1; DN -> AT1, setting floor=0; both after TRAVEL_T ticks.
- AT1 and AT2 -> IDLE after DWELL_T ticks.
- Calls during REQ, UP, DN or AT are latched only and never preempt the running phase. A call for the destination merges into the current trip. A call for the origin floor is served after dwell by the normal IDLE path.
- If both floors are pending in IDLE, the current floor is served first.
- tick=0 freezes timers, but calls are still latched.
- An asynchronous reset mid-travel returns to floor=0, IDLE immediately. No recovery of position.

Optional Feature:
- Macro: LIFT_AUTO_RETURN_EN.
- Defined:
  - Adds parameter PARK_T (default 8).
  - In IDLE with floor=1 and nothing pending, a park timer counts ticks; any call resets it.
  - After PARK_T ticks, go straight to DN with no REQ1 display, then AT1, then IDLE.
  - The park timer resets on leaving IDLE.
- Undefined: the lift stays at its last floor indefinitely. Neither the park timer nor PARK_T exists.

Decomposition:
- Package lift_pkg holds:
  - the action code constants (ACT_DN … ACT_NOTHING, matching the coder encoding);
  - the state enum;
  - the default timing constants.
- Sub-module lift_phase_timer: TW-bit loadable down-counter with load, tick and done (timer==0 && tick). It is instantiated once, plus once more for the park timer when LIFT_AUTO_RETURN_EN is defined.

Test Plan:
- Reset idle: assert rst mid-cycle with no clk edge -> action=110, floor=0, busy=0 immediately, and held for 20 cycles after release.
- Full trip up, tick=1 constantly, defaults: one-cycle pulse on call2 at cycle 0 -> action 101 for cycles 1-2, 010 for 3-7, 011 for 8-11 with floor=1 from cycle 8, then 110 at cycle 12.
- Same-floor call: at floor 0, call1 pulse -> action goes 001 immediately for 4 cycles, never showing 100 or 010.
- Merged/queued calls: call2 pulse, then call1 during UP -> after AT2 the sequence is 100 (2), 000 (5), 001 (4), 110; pending2 is not re-served.
- Tick gating: tick asserted once every 3 clk, call2 pulse -> REQ2 lasts exactly 6 clk, UP lasts 15 clk; a call1 during the gap between ticks is still latched.
- Reset mid-travel: rst during UP cycle 5 -> action=110, floor=0, pending flags 0. With LIFT_AUTO_RETURN_EN and PARK_T=8: idle at floor 1 -> 000 after 8 ticks, then 001, then 110.
